// File: rtl/pmu_pkg.sv
// Shared PMU definitions: instruction encodings and the readback serializer state set.
package pmu_pkg;

    localparam logic [3:0] INSTR_SCAN = 4'd0;
    localparam logic [3:0] INSTR_MEM  = 4'd1;
    localparam logic [3:0] INSTR_AES  = 4'd2;
    localparam logic [3:0] INSTR_KEY  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } piso_state_t;

endpackage

// File: rtl/piso_shifter.sv
// Datapath of the readback serializer: shift register, bit counter and, with PISO_PARITY_EN,
// the running even-parity accumulator over emitted bits.
module piso_shifter #(
    parameter int unsigned AES_DATA_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      load_wide,
    input  logic [AES_DATA_WIDTH-1:0] aes_data_i,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
    input  logic                      shift,
    input  logic                      clear,
    output logic                      bit0,
`ifdef PISO_PARITY_EN
    output logic                      parity,
`endif
    output logic                      last
);

    logic [AES_DATA_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [CNT_WIDTH-1:0]      len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            cnt   <= '0;
            len   <= '0;
        end else if (load) begin
            shreg <= load_wide ? aes_data_i
                               : {{(AES_DATA_WIDTH-MEM_DATA_WIDTH){1'b0}}, mem_data_i};
            len   <= load_wide ? CNT_WIDTH'(AES_DATA_WIDTH) : CNT_WIDTH'(MEM_DATA_WIDTH);
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CNT_WIDTH'(1);
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity <= 1'b0;
        end else if (load || clear) begin
            parity <= 1'b0;
        end else if (shift) begin
            parity <= parity ^ shreg[0];
        end
    end
`endif

    assign bit0 = shreg[0];
    assign last = (cnt == len - CNT_WIDTH'(1));

endmodule

// File: rtl/piso_readback.sv
// PMU readback serializer: captures an AES/scan or memory word and emits it LSB-first under en.
// Optional PISO_PARITY_EN appends one even-parity bit per frame.
module piso_readback
    import pmu_pkg::*;
#(
    parameter int unsigned AES_DATA_WIDTH = 128,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [3:0]                instruction,
    input  logic [AES_DATA_WIDTH-1:0] aes_data_i,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i,
    output logic                      data_o,
    output logic                      valid_o,
    output logic                      busy,
    output logic                      done
);

    piso_state_t state;
    logic        load_ok;
    logic        sh_load;
    logic        sh_shift;
    logic        sh_clear;
    logic        sh_bit0;
    logic        sh_last;
`ifdef PISO_PARITY_EN
    logic        sh_parity;
`endif

    // Key material (INSTR_KEY) and unassigned codes never start a frame.
    assign load_ok = (instruction == INSTR_SCAN) || (instruction == INSTR_MEM) ||
                     (instruction == INSTR_AES);

    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        case (state)
            ST_IDLE:  sh_load  = load && load_ok;
            ST_SHIFT: sh_shift = en;
            ST_DONE:  sh_clear = 1'b1;
            default:  ;
        endcase
    end

    piso_shifter #(
        .AES_DATA_WIDTH (AES_DATA_WIDTH),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .load_wide  (instruction != INSTR_MEM),
        .aes_data_i (aes_data_i),
        .mem_data_i (mem_data_i),
        .shift      (sh_shift),
        .clear      (sh_clear),
        .bit0       (sh_bit0),
`ifdef PISO_PARITY_EN
        .parity     (sh_parity),
`endif
        .last       (sh_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            data_o  <= 1'b0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    valid_o <= 1'b0;
                    if (load && load_ok) begin
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        data_o  <= sh_bit0;
                        valid_o <= 1'b1;
                        if (sh_last) begin
`ifdef PISO_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_DONE;
`endif
                        end
                    end else begin
                        valid_o <= 1'b0;
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    if (en) begin
                        data_o  <= sh_parity;
                        valid_o <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        valid_o <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    valid_o <= 1'b0;
                    data_o  <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_readback.sv
// Scoreboard bench for piso_readback: stimulus pushes expected bits/frames, a monitor pops on valid_o/done.
// Honours PISO_PARITY_EN when defined for the build.
module tb_piso_readback;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic [127:0] word;
        int           len;
        int           nbits;
    } frame_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [3:0]   instruction;
    logic [127:0] aes_data_i;
    logic [31:0]  mem_data_i;
    logic         data_o;
    logic         valid_o;
    logic         busy;
    logic         done;

    int     compared   = 0;
    int     mismatched = 0;
    logic   exp_bits[$];
    frame_t frames[$];
    logic [128:0] rcv;
    int     rcv_n = 0;

    piso_readback #(
        .AES_DATA_WIDTH (128),
        .MEM_DATA_WIDTH (32),
        .CNT_WIDTH      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .instruction (instruction),
        .aes_data_i  (aes_data_i),
        .mem_data_i  (mem_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: a frame is the word's low len bits LSB-first, optionally followed by their XOR.
    task automatic expect_frame(input logic [127:0] w, input int len);
        frame_t f;
        for (int i = 0; i < len; i++) exp_bits.push_back(w[i]);
        if (PAR == 1) exp_bits.push_back(^w);
        f.word  = w;
        f.len   = len;
        f.nbits = len + PAR;
        frames.push_back(f);
    endtask

    // Monitor: acts as the loader, rebuilding each frame and comparing at done.
    initial begin
        frame_t       f;
        logic         eb;
        logic [127:0] rebuilt;
        rcv = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rcv_n = 0;
                rcv   = '0;
            end else begin
                if (valid_o) begin
                    if (exp_bits.size() == 0) begin
                        chk1("unexpected_bit", valid_o, 1'b0);
                    end else begin
                        eb = exp_bits.pop_front();
                        chk1("serial_bit", data_o, eb);
                    end
                    if (rcv_n < 129) rcv[rcv_n] = data_o;
                    rcv_n++;
                end
                if (done) begin
                    chk1("busy_at_done", busy, 1'b0);
                    if (frames.size() == 0) begin
                        chk1("unexpected_done", done, 1'b0);
                    end else begin
                        f = frames.pop_front();
                        chkn("frame_bit_count", 128'(rcv_n), 128'(f.nbits));
                        rebuilt = '0;
                        for (int i = 0; i < f.len; i++) rebuilt[i] = rcv[i];
                        chkn("loopback_word", rebuilt, f.word);
                    end
                    rcv_n = 0;
                    rcv   = '0;
                end
            end
        end
    end

    // mode 0: en held 1 (optional 50-cycle stall), 1: en toggling, 2: en random
    task automatic do_frame(input logic [3:0] instr, input logic [127:0] aes, input logic [31:0] mem,
                            input int mode, input bit extra_load, input bit stall);
        bit accepted;
        bit got;
        int len;
        int cyc;
        accepted    = (instr == 4'd0) || (instr == 4'd1) || (instr == 4'd2);
        len         = (instr == 4'd1) ? 32 : 128;
        aes_data_i  = aes;
        mem_data_i  = mem;
        instruction = instr;
        load        = 1'b1;
        en          = 1'b1;
        if (accepted) expect_frame((instr == 4'd1) ? {96'b0, mem} : aes, len);
        @(posedge clk); #1;
        load = 1'b0;
        chk1("busy_after_load", busy, accepted);
        if (!accepted) begin
            repeat (4) @(posedge clk);
            #1;
            chk1("ignored_valid", valid_o, 1'b0);
            chk1("ignored_data", data_o, 1'b0);
            en = 1'b0;
            return;
        end
        aes_data_i  = rand128();
        mem_data_i  = $urandom;
        instruction = 4'($urandom_range(0, 15));
        cyc = 0;
        got = 1'b0;
        while (cyc < 2000) begin
            case (mode)
                0:       en = !(stall && cyc >= 15 && cyc < 65);
                1:       en = (cyc % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            if (extra_load && cyc == 10) begin
                load        = 1'b1;
                instruction = 4'd1;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        load = 1'b0;
        en   = 1'b0;
        if (!got) chk1("frame_timeout", done, 1'b1);
        else if (mode == 0) chkn("done_latency", 128'(cyc), 128'(len + PAR + 1 + (stall ? 50 : 0)));
    endtask

    initial begin
        logic [31:0] w;
        int          sel;
        en = 1'b0; load = 1'b0; instruction = '0; aes_data_i = '0; mem_data_i = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk1("reset_data", data_o, 1'b0);
        chk1("reset_valid", valid_o, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        do_frame(4'd1, '0, 32'hA5A5_0F01, 0, 1'b0, 1'b0);
        do_frame(4'd0, rand128(), '0, 1, 1'b0, 1'b0);
        do_frame(4'd2, rand128(), '0, 2, 1'b0, 1'b0);
        do_frame(4'd3, rand128(), $urandom, 0, 1'b0, 1'b0);
        do_frame(4'd7, rand128(), $urandom, 0, 1'b0, 1'b0);
        do_frame(4'd1, '0, $urandom, 0, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            sel = $urandom_range(0, 2);
            do_frame(4'(sel), rand128(), $urandom, $urandom_range(0, 2), 1'b0, 1'b0);
        end

        // Reset mid-frame: outputs clear without an edge, frame is dropped.
        w           = $urandom | 32'h1;
        instruction = 4'd1;
        mem_data_i  = w;
        load        = 1'b1;
        en          = 1'b1;
        expect_frame({96'b0, w}, 32);
        @(posedge clk); #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk1("midreset_data", data_o, 1'b0);
        chk1("midreset_valid", valid_o, 1'b0);
        chk1("midreset_busy", busy, 1'b0);
        chk1("midreset_done", done, 1'b0);
        exp_bits.delete();
        frames.delete();
        rcv_n = 0;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_frame(4'd1, '0, $urandom, 0, 1'b0, 1'b0);

        do_frame(4'd1, '0, 32'h0000_0007, 0, 1'b0, 1'b0);
        do_frame(4'd1, '0, 32'h0000_0003, 0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chkn("leftover_bits", 128'(exp_bits.size()), 128'(0));
        chkn("leftover_frames", 128'(frames.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_readback.md
# piso_readback

Parallel-in serial-out readback serializer for the PMU: the transmit-side counterpart of the serial loader. Captures a 128-bit AES/scan-chain result or a 32-bit memory read word and shifts it out LSB-first on a single serial line toward the PC, gated by a shift strobe. The bit order matches the loader, so a word serialized here and fed into the loader is reproduced exactly. Key material is never serialized.

## Interface
- AES_DATA_WIDTH, 128, width of AES/scan-chain readback word
- MEM_DATA_WIDTH, 32, width of memory readback word
- CNT_WIDTH, 8, bit-counter width; must hold AES_DATA_WIDTH+1
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  shift strobe; one bit is emitted per cycle with en=1 while shifting
- load  input  1  capture request, sampled only in IDLE
- instruction  input  4  source select at load: 0 = scan chain, 1 = memory, 2 = AES
- aes_data_i  input  AES_DATA_WIDTH  AES/scan-chain word
- mem_data_i  input  MEM_DATA_WIDTH  memory read word
- data_o  output  1  serial data, registered
- valid_o  output  1  data_o holds a fresh bit this cycle
- busy  output  1  frame in progress, load ignored
- done  output  1  one-cycle pulse at frame end

## Operation
- Reset (rst=0, async): state IDLE; shift register, counter, data_o, valid_o, busy, done all 0.
- States: IDLE, SHIFT, PARITY (only when the macro is defined), DONE.
- IDLE: load=1 with instruction 0 or 2 -> shreg <= aes_data_i, len <= AES_DATA_WIDTH. With instruction 1 -> shreg <= zero-extended mem_data_i, len <= MEM_DATA_WIDTH. In all three cases cnt <= 0, busy <= 1, go to SHIFT. Instruction 3 (key) and 4–15 are ignored: state stays IDLE, busy stays 0.
- SHIFT, en=1: data_o <= shreg[0]; valid_o <= 1; shreg <= shreg >> 1; cnt <= cnt+1. When cnt == len-1, go to DONE, or to PARITY if the macro is defined.
- SHIFT, en=0: valid_o <= 0; data_o holds; shreg and cnt hold. This is a stall with no timeout.
- DONE: valid_o <= 0; data_o <= 0; done <= 1 for one cycle; busy <= 0; shreg <= 0 (scrub); go to IDLE.
- load while busy: ignored, not queued.
- Changes on instruction or data inputs after capture have no effect on the frame in flight.

## Timing
- Load sampled at edge N: busy=1 after N. First bit is on data_o with valid_o=1 after the first edge with en=1 in SHIFT, earliest N+1.
- With en held at 1: bit k appears after edge N+1+k. The last data bit appears after N+len.
- done=1 and busy=0 after edge N+len+1, or N+len+2 with parity.
- Earliest next load is sampled at edge N+len+2.
- Reset mid-frame: all outputs go to 0 immediately, without waiting for a clock edge. The frame is lost, no done pulse is issued, and the next load is accepted on the first edge after rst releases.
- Simultaneous load and en in IDLE: load wins and no bit is emitted that cycle.

## Configuration
- PISO_PARITY_EN defined: after the last data bit, one extra en-gated bit is emitted from state PARITY. Its value is the XOR of all emitted data bits (even parity), and valid_o=1 for it. Frame length is len+1.
- Undefined: there is no PARITY state, frame length is exactly len, and the parity accumulator is not synthesized.

## Structure
- Shared package pmu_pkg holds the following. Data and counter widths stay module parameters.
  - Instruction encodings: INSTR_SCAN=0, INSTR_MEM=1, INSTR_AES=2, INSTR_KEY=3.
  - The state enum.
- Sub-module piso_shifter holds the shift register, bit counter and parity accumulator (load/shift/clear controls, last-bit flag). The top holds the FSM and output registers.

## Test plan
- Reset: assert rst=0 mid-run -> data_o, valid_o, busy, done are all 0 with no clock edge. Load 1 edge after release -> accepted.
- instruction=1, mem_data_i=0xA5A50F01, en=1: 32 valid bits 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,… (LSB-first). done pulses one cycle at N+33, busy falls with it.
- instruction=0, en toggling 1/0, random 128-bit word: exactly 128 valid_o pulses. Looped back through the loader, the loader reproduces the word.
- instruction=3, load=1 -> busy stays 0, valid_o never 1, data_o stays 0. The same applies to instruction=7.
- Second load at bit 10 of a memory frame -> ignored and the frame completes unchanged. en=0 held for 50 cycles mid-frame -> no bits lost.
- PISO_PARITY_EN, mem_data_i=0x00000007 -> 33 valid bits, last bit 1. With mem_data_i=0x00000003 -> last bit 0.
